// File: rtl/arm_main_fsm_if.sv
// Control bundle between the multicycle ARM main FSM and its datapath.
// The FSM takes the master side: it reads the instruction fields and drives the controls.
interface arm_main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  Op, Funct, mem_ready,
    output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done, state
  );

  modport slave (
    output Op, Funct, mem_ready,
    input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done, state
  );
endinterface

// File: rtl/arm_main_fsm.sv
// Main control FSM for the multicycle ARM datapath (Moore outputs decoded from state).
// Optional ARM_MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall until mem_ready is high.
module arm_main_fsm (
  input  logic          clk,
  input  logic          rst_n,
  arm_main_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_e;

  state_e state_q;
  logic   ready;

`ifdef ARM_MEM_WAIT_EN
  assign ready = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:    if (ready) state_q <= DECODE;
        DECODE: begin
          case (bus.Op)
            2'b00:   state_q <= bus.Funct[5] ? EXECUTEI : EXECUTER;
            2'b01:   state_q <= MEMADR;
            2'b10:   state_q <= BRANCH;
            default: state_q <= FETCH;  // undefined opcode is dropped silently
          endcase
        end
        MEMADR:   state_q <= bus.Funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  if (ready) state_q <= MEMWB;
        MEMWB:    state_q <= FETCH;
        MEMWRITE: if (ready) state_q <= FETCH;
        EXECUTER: state_q <= ALUWB;
        EXECUTEI: state_q <= ALUWB;
        ALUWB:    state_q <= FETCH;
        BRANCH:   state_q <= FETCH;
        default:  state_q <= FETCH;
      endcase
    end
  end

  always_comb begin
    bus.IRWrite    = 1'b0;
    bus.NextPC     = 1'b0;
    bus.RegW       = 1'b0;
    bus.MemW       = 1'b0;
    bus.Branch     = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUOp      = 1'b0;
    bus.instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        // PC must advance exactly once even when the fetch is stalled
        bus.IRWrite   = ready;
        bus.NextPC    = ready;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc  = 2'b01;
        bus.RegW       = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc     = 1'b1;
        bus.MemW       = 1'b1;
        bus.instr_done = ready;
      end
      EXECUTER: begin
        bus.ALUOp = 1'b1;
      end
      EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
      end
      ALUWB: begin
        bus.RegW       = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcB    = 2'b01;
        bus.ResultSrc  = 2'b10;
        bus.Branch     = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase

    // Reset kills every strobe immediately and parks the selects at their fetch setting
    if (!rst_n) begin
      bus.IRWrite    = 1'b0;
      bus.NextPC     = 1'b0;
      bus.RegW       = 1'b0;
      bus.MemW       = 1'b0;
      bus.Branch     = 1'b0;
      bus.instr_done = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.ALUSrcA    = 2'b01;
      bus.ALUSrcB    = 2'b10;
      bus.ResultSrc  = 2'b10;
      bus.ALUOp      = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule
